// File: rtl/pck_socket_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pck_socket_fifo
//  Description : Socket-side input buffer in front of a PCK processing module.
//                Words arrive on a data/dv push port. They are handed to the
//                module through a registered pop port with one cycle of read
//                latency. The empty state is reported back upstream.
//                Full and empty come from an occupancy counter, not from
//                comparing the pointers.
//  Options     : `define PCK_SOCKET_FIFO_STATS_EN adds the ovf_cnt, udf_cnt
//                and err_sticky error-statistics outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module pck_socket_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_dv,
  output logic                       in_empty,
  output logic                       almost_full,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_dv,
  output logic                       out_full,
  input  logic                       out_rd_en,
`ifdef PCK_SOCKET_FIFO_STATS_EN
  output logic [15:0]                ovf_cnt,
  output logic [15:0]                udf_cnt,
  output logic                       err_sticky,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_afull = CNT_W'(AFULL_LEVEL);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
  localparam logic [PTR_W-1:0] c_ptr1  = PTR_W'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;

  logic                  w_not_empty;
  logic                  w_not_full;
  logic                  w_pop;
  logic                  w_push;
  logic [CNT_W-1:0]      w_count_nxt;

  // A pop needs a stored word. A push needs a free slot, or a slot freed by
  // a pop in the same cycle. An empty FIFO never falls through.
  always_comb begin
    w_not_empty = (count != '0);
    w_not_full  = (count < c_depth);
    w_pop       = out_rd_en && w_not_empty;
    w_push      = in_dv && (w_not_full || w_pop);
  end

  // Next occupancy: push-only adds one, pop-only removes one, both or neither hold.
  always_comb begin
    w_count_nxt = count;
    if (w_push && !w_pop) begin
      w_count_nxt = count + c_one;
    end else if (w_pop && !w_push) begin
      w_count_nxt = count - c_one;
    end
  end

  // Pointers and occupancy; the pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      count    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr1;
      end
      count <= w_count_nxt;
    end
  end

  // Storage array. It has no reset: its contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Read port: register the head word on a pop and pulse out_dv for one cycle.
  // When no pop is accepted, out_data keeps its last value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_data <= '0;
      out_dv   <= 1'b0;
    end else begin
      out_dv <= w_pop;
      if (w_pop) begin
        out_data <= r_mem[r_rd_ptr];
      end
    end
  end

  // Status flags are registered from the post-update count.
  // They therefore track count exactly, with no extra cycle of lag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_empty    <= 1'b1;
      out_full    <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      in_empty    <= (w_count_nxt == '0);
      out_full    <= (w_count_nxt == c_depth);
      almost_full <= (w_count_nxt >= c_afull);
    end
  end

`ifdef PCK_SOCKET_FIFO_STATS_EN
  logic w_drop;
  logic w_refuse;

  // Error events: a push dropped while full, or a pop refused while empty.
  always_comb begin
    w_drop   = in_dv && !w_push;
    w_refuse = out_rd_en && !w_pop;
  end

  // Saturating error counters, plus a sticky flag. Only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_cnt    <= '0;
      udf_cnt    <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (w_drop && (ovf_cnt != 16'hFFFF)) begin
        ovf_cnt <= ovf_cnt + 16'd1;
      end
      if (w_refuse && (udf_cnt != 16'hFFFF)) begin
        udf_cnt <= udf_cnt + 16'd1;
      end
      if (w_drop || w_refuse) begin
        err_sticky <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pck_socket_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pck_socket_fifo
//  Description : Self-checking bench for pck_socket_fifo. Each accepted push
//                is queued as an expected output word. The head of the queue
//                is compared when the DUT raises out_dv. The bench keeps its
//                own count of occupancy, flags and (optionally) error
//                statistics, and checks them after every clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pck_socket_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFULL = 14;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_dv = 1'b0;
  logic          in_empty;
  logic          almost_full;
  logic [DW-1:0] out_data;
  logic          out_dv;
  logic          out_full;
  logic          out_rd_en = 1'b0;
  logic [CW-1:0] count;
`ifdef PCK_SOCKET_FIFO_STATS_EN
  logic [15:0]   ovf_cnt;
  logic [15:0]   udf_cnt;
  logic          err_sticky;
`endif

  pck_socket_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (AFULL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_dv       (in_dv),
    .in_empty    (in_empty),
    .almost_full (almost_full),
    .out_data    (out_data),
    .out_dv      (out_dv),
    .out_full    (out_full),
    .out_rd_en   (out_rd_en),
`ifdef PCK_SOCKET_FIFO_STATS_EN
    .ovf_cnt     (ovf_cnt),
    .udf_cnt     (udf_cnt),
    .err_sticky  (err_sticky),
`endif
    .count       (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side state: the scoreboard of expected words and the predicted state.
  logic [DW-1:0] sb_q[$];
  int            m_count = 0;
  logic [DW-1:0] m_last  = '0;
  int            m_ovf   = 0;
  int            m_udf   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, predict its effect, and then check the DUT
  // just after the clock edge.
  task automatic cycle(input logic rst_n, input logic dv, input logic [DW-1:0] d, input logic rd);
    bit pop_ok;
    bit push_ok;
    logic [DW-1:0] exp_word;
    rst       = rst_n;
    in_dv     = dv;
    in_data   = d;
    out_rd_en = rd;
    if (!rst_n) begin
      pop_ok  = 1'b0;
      push_ok = 1'b0;
      m_count = 0;
      m_last  = '0;
      m_ovf   = 0;
      m_udf   = 0;
      sb_q.delete();
    end else begin
      pop_ok  = rd && (m_count > 0);
      push_ok = dv && ((m_count < DEPTH) || pop_ok);
      if (push_ok) sb_q.push_back(d);
      if (dv && !push_ok && m_ovf < 16'hFFFF) m_ovf++;
      if (rd && !pop_ok && m_udf < 16'hFFFF) m_udf++;
      if (push_ok && !pop_ok) m_count++;
      if (pop_ok && !push_ok) m_count--;
    end
    @(posedge clk);
    #1;
    check("out_dv", 32'(out_dv), 32'(pop_ok));
    if (out_dv) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        exp_word = sb_q.pop_front();
        check("out_data", 32'(out_data), 32'(exp_word));
        m_last = exp_word;
      end
    end else begin
      check("out_data_hold", 32'(out_data), 32'(m_last));
    end
    check("count", 32'(count), 32'(m_count));
    check("in_empty", 32'(in_empty), 32'(m_count == 0));
    check("out_full", 32'(out_full), 32'(m_count == DEPTH));
    check("almost_full", 32'(almost_full), 32'(m_count >= AFULL));
`ifdef PCK_SOCKET_FIFO_STATS_EN
    check("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
    check("udf_cnt", 32'(udf_cnt), 32'(m_udf));
    check("err_sticky", 32'(err_sticky), 32'((m_ovf + m_udf) != 0));
`endif
  endtask

  initial begin
    // Reset held for 3 cycles with push and pop requested; both must be ignored.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'hEE, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);

    // Fill with 0x01..0x10; almost_full rises at 14 and out_full at 16.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b1, DW'(i), 1'b0);
    check("filled_full", 32'(out_full), 32'd1);

    // Overflow: this push is dropped and count stays at DEPTH.
    cycle(1'b1, 1'b1, 8'hAA, 1'b0);
`ifdef PCK_SOCKET_FIFO_STATS_EN
    check("ovf_after_drop", 32'(ovf_cnt), 32'd1);
    check("sticky_after_drop", 32'(err_sticky), 32'd1);
`endif

    // Full with a simultaneous push and pop: 0x01 emerges and 0x55 is stored.
    cycle(1'b1, 1'b1, 8'h55, 1'b1);
    check("full_pushpop_data", 32'(out_data), 32'h01);
    check("full_pushpop_count", 32'(count), 32'd16);

    // Drain: 0x02..0x10, then 0x55; one extra pop is refused on the empty FIFO.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
    check("drain_last", 32'(out_data), 32'h55);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);

    // Empty corner: the push is stored and the pop is refused (no fall-through).
    cycle(1'b1, 1'b1, 8'h33, 1'b1);
    check("empty_corner_count", 32'(count), 32'd1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    check("empty_corner_data", 32'(out_data), 32'h33);

    // Random traffic crossing the pointer wrap point several times.
    for (int i = 0; i < 40; i++)
      cycle(1'b1, 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));

    // Reset mid-operation discards the contents and clears the statistics.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, DW'(8'hC0 + i), 1'b0);
    cycle(1'b0, 1'b1, 8'h77, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 1'b1, 8'h9C, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
